mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Shares one pipelined signed W x W multiplier (ports A, B, P, en; fixed LATENCY) among N_REQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle.
- An in-flight ID pipeline of depth LATENCY tracks every issued product; each result is routed back to its requester as a one-cycle response pulse.
- A halt/drain state machine lets the system quiesce the multiplier, for example before reconfiguration or clock gating.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 6, operand width, signed two's complement.
- PW, 2*W-1 (11), product width; matches multiplier P.
- LATENCY, 7, multiplier cycles from A/B stable at input to P valid.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- req_a  in  N_REQ*W  packed operand A, requester i at [i*W +: W]
- req_b  in  N_REQ*W  packed operand B
- rsp_valid  out  N_REQ  one-hot result pulse
- rsp_p  out  PW  signed product for the pulsing requester
- halt  in  1  request to stop issuing and drain
- idle  out  1  high when HALTED and no products are in flight
- mul_a  out  W  to multiplier A (registered)
- mul_b  out  W  to multiplier B (registered)
- mul_en  out  1  to multiplier en
- mul_p  in  PW  from multiplier P

Behaviour:
- Reset (async, rst_n=0) drives these values:
  - req_ready=0, rsp_valid=0, rsp_p=0, mul_a=0, mul_b=0, mul_en=0, idle=0.
  - ID pipeline cleared; RR pointer=0; state=RUN.
- mul_en=1 from the first rising edge after reset release, constant thereafter. The pipeline is free-running and the arbiter never stalls it.
- Arbitration (state RUN only):
  - req_ready is combinational from req_valid and the pointer.
  - Grant goes to the first asserted req_valid at index >= ptr, wrapping to 0.
  - On accept at a rising edge, ptr <= granted index + 1 (mod N_REQ).
  - No request: no grant, and ptr is unchanged.
- Issue: the accept edge loads mul_a/mul_b with the granted operands and pushes {valid=1, id} into the ID shift register. A cycle with no accept pushes valid=0. mul_a/mul_b hold their last values when nothing is accepted.
- Response timing:
  - Shift-register slot LATENCY aligns with mul_p.
  - On the edge where that slot is valid, rsp_p <= mul_p and rsp_valid <= onehot(id).
  - Accept at edge t gives rsp_valid high for exactly one cycle after edge t+LATENCY+1 (8 edges at default).
- Requesters must accept responses; there is no response backpressure.
- Throughput is 1 product per cycle. Ordering is issue order, and is preserved per requester.
- Arithmetic:
  - rsp_p = (req_a * req_b) truncated to PW bits, signed.
  - (-2^(W-1))^2 wraps: -32*-32 gives -1024.
- State machine:
  - RUN: grants enabled. halt=1 goes to DRAIN at the next edge. A grant issued in the same cycle as halt rising is still accepted.
  - DRAIN: req_ready=0. When no valid entries remain in the ID pipeline, go to HALTED.
  - HALTED: req_ready=0, idle=1. halt=0 returns to RUN at the next edge, and idle falls at that edge.
  - halt deasserted during DRAIN returns to RUN immediately; in-flight entries are unaffected.
- Reset mid-operation: all in-flight entries are discarded. No rsp_valid is emitted for them, even after rst_n returns.

Optional Feature:
MUL_ARB_PRIO_EN:
- Defined: requester 0 has fixed highest priority. It is granted whenever req_valid[0]=1. The round-robin rule applies only among requesters 1..N_REQ-1, and ptr updates only on their grants.
- Undefined: pure round-robin over all N_REQ.

Test Plan:
- Single request: req0 a=5, b=-3 accepted at edge 0 -> rsp_valid=4'b0001 after edge 8, rsp_p=-15, one cycle only; idle stays 0.
- Full sweep: all a,b in -32..31 issued back-to-back from req2 -> every rsp_p equals the 11-bit truncated product (-32*-32 gives -1024), 1 result per cycle, in order.
- Contention: all 4 valid continuously from reset -> grant order 0,1,2,3,0,...; rsp_valid one-hot in that same order, starting at edge 8.
- Halt: halt at cycle 20 with 7 products in flight -> no grants after edge 20, all 7 responses delivered, idle=1 one cycle after the last pulse; halt=0 -> grants resume next cycle.
- Reset mid-stream: rst_n low for 2 cycles with 5 in flight -> outputs immediately at reset values; no stale rsp_valid afterwards; the first new request returns a correct product 8 edges after accept.
- MUL_ARB_PRIO_EN defined, req0..req3 all valid -> req0 granted every cycle. Drop req0 -> grants go to 1,2,3 round-robin.

Source files
------------

// File: rtl/mul_share_arb.sv
`default_nettype none
//==============================================================================
// Module      : mul_share_arb
// Description : Round-robin sharing of one external pipelined signed W x W
//               multiplier among N_REQ requesters. An ID shift register tracks
//               every issued operand pair so each product returns to its
//               requester as a one-cycle rsp_valid pulse. A RUN/DRAIN/HALTED
//               state machine lets the system quiesce the multiplier.
//               Optional build macro MUL_ARB_PRIO_EN: requester 0 gets fixed
//               highest priority; round-robin applies to requesters 1..N_REQ-1.
// Revision    : 1.0 - initial release
//==============================================================================
module mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int W       = 6,
    parameter int PW      = 2*W-1,
    parameter int LATENCY = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [PW-1:0]      rsp_p,
    input  logic               halt,
    output logic               idle,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    output logic               mul_en,
    input  logic [PW-1:0]      mul_p
);

    localparam int               c_IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_IDW:0]   c_NREQ = (c_IDW+1)'(N_REQ);
    localparam logic [c_IDW-1:0] c_LAST = c_IDW'(N_REQ-1);
    localparam logic [c_IDW-1:0] c_ONE  = c_IDW'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [c_IDW-1:0]            r_ptr;
    // Slot k holds the entry accepted k edges ago; slot LATENCY lines up with mul_p.
    logic [LATENCY:0]            r_sr_vld;
    logic [LATENCY:0][c_IDW-1:0] r_sr_id;

    logic [N_REQ-1:0]            w_cand;
    logic [2*N_REQ-1:0]          w_dbl;
    logic [N_REQ-1:0]            w_rot;
    logic                        w_found;
    logic [c_IDW-1:0]            w_off;
    logic [c_IDW:0]              w_sum;
    logic [c_IDW-1:0]            w_gnt_idx;
    logic                        w_accept;
    logic                        w_ptr_upd;
    logic [W-1:0]                w_sel_a;
    logic [W-1:0]                w_sel_b;
    logic                        w_inflight;

    // Round-robin arbiter: rotate candidates so the pointer sits at bit 0,
    // pick the lowest set bit, then rotate the index back.
    always_comb begin
        w_cand = req_valid;
`ifdef MUL_ARB_PRIO_EN
        w_cand[0] = 1'b0;
`endif
        w_dbl   = {w_cand, w_cand} >> r_ptr;
        w_rot   = w_dbl[N_REQ-1:0];
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = c_IDW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_NREQ) begin
            w_gnt_idx = c_IDW'(w_sum - c_NREQ);
        end else begin
            w_gnt_idx = w_sum[c_IDW-1:0];
        end
`ifdef MUL_ARB_PRIO_EN
        // Requester 0 overrides the rotating search whenever it asks.
        if (req_valid[0]) begin
            w_found   = 1'b1;
            w_gnt_idx = '0;
        end
`endif
        // Grants are held off while in reset so req_ready reads 0 immediately.
        w_accept  = w_found && (r_state == ST_RUN) && rst_n;
        req_ready = w_accept ? (N_REQ'(1) << w_gnt_idx) : '0;
`ifdef MUL_ARB_PRIO_EN
        w_ptr_upd = w_accept && (w_gnt_idx != '0);
`else
        w_ptr_upd = w_accept;
`endif
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
            end
        end
    end

    assign w_inflight = |r_sr_vld;
    assign idle       = (r_state == ST_HALTED) && !w_inflight;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping halt always wins and returns to RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (halt) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!halt)           w_state_nxt = ST_RUN;
                else if (!w_inflight) w_state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Issue side: pointer, multiplier operands and free-running enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_en <= 1'b0;
        end else begin
            mul_en <= 1'b1;
            if (w_accept) begin
                mul_a <= w_sel_a;
                mul_b <= w_sel_b;
            end
            if (w_ptr_upd) begin
                r_ptr <= (w_gnt_idx == c_LAST) ? '0 : (w_gnt_idx + c_ONE);
            end
        end
    end

    // In-flight ID pipeline and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_vld  <= '0;
            r_sr_id   <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else begin
            r_sr_vld <= {r_sr_vld[LATENCY-1:0], w_accept};
            r_sr_id  <= {r_sr_id[LATENCY-1:0], w_gnt_idx};
            if (r_sr_vld[LATENCY]) begin
                rsp_valid <= N_REQ'(1) << r_sr_id[LATENCY];
                rsp_p     <= mul_p;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
//==============================================================================
// Module      : tb_mul_share_arb
// Description : Directed self-checking bench for mul_share_arb with a
//               behavioural 7-stage signed multiplier attached.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mul_share_arb;

    localparam int N_REQ   = 4;
    localparam int W       = 6;
    localparam int PW      = 11;
    localparam int LATENCY = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   rsp_valid;
    logic [PW-1:0]      rsp_p;
    logic               halt;
    logic               idle;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic               mul_en;
    logic [PW-1:0]      mul_p;

    int n_pass  = 0;
    int n_total = 0;

    mul_share_arb #(.N_REQ(N_REQ), .W(W), .PW(PW), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p),
        .halt(halt), .idle(idle),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p)
    );

    always #5 clk = ~clk;

    // External multiplier: operands registered by the DUT, product 7 edges later.
    logic [PW-1:0] m_pipe [0:LATENCY-1];
    logic [PW-1:0] m_ea;
    logic [PW-1:0] m_eb;
    assign m_ea  = {{(PW-W){mul_a[W-1]}}, mul_a};
    assign m_eb  = {{(PW-W){mul_b[W-1]}}, mul_b};
    assign mul_p = m_pipe[LATENCY-1];
    always @(posedge clk) begin
        if (mul_en) begin
            m_pipe[0] <= m_ea * m_eb;
            for (int k = 1; k < LATENCY; k++) m_pipe[k] <= m_pipe[k-1];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ops(input int idx, input int a, input int b);
        req_a[idx*W +: W] = W'(a);
        req_b[idx*W +: W] = W'(b);
    endtask

    function automatic logic [31:0] pv(input int v);
        return {21'b0, v[PW-1:0]};
    endfunction

    // Expected grant in the all-valid contention run, c = accept edge.
    function automatic logic [31:0] exp_rr(input int c);
`ifdef MUL_ARB_PRIO_EN
        return 32'h1;
`else
        return 32'h1 << (c % 4);
`endif
    endfunction

    function automatic int exp_id(input int j);
`ifdef MUL_ARB_PRIO_EN
        return 0;
`else
        return j % 4;
`endif
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  req_ready, 32'h0);
        chk({tag, "_rspv"},   rsp_valid, 32'h0);
        chk({tag, "_rspp"},   rsp_p,     32'h0);
        chk({tag, "_mula"},   mul_a,     32'h0);
        chk({tag, "_mulb"},   mul_b,     32'h0);
        chk({tag, "_mulen"},  mul_en,    32'h0);
        chk({tag, "_idle"},   idle,      32'h0);
    endtask

    int pa [4] = '{1, 2, 3, 4};
    int pb [4] = '{-2, -3, -4, -5};

    initial begin
        int            a, b, p, j;
        logic [31:0]   e;

        // ---------------- reset values (requests asserted, must not grant)
        rst_n     = 1'b0;
        halt      = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        #12;
        chk_reset_vals("rst");
        tick();

        // ---------------- single request: 5 * -3 from requester 0
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        set_ops(0, 5, -3);
        rst_n     = 1'b1;
        #1;
        chk("single_ready", req_ready, 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("single_mulen", mul_en, 32'h1);
        chk("single_mula",  mul_a,  32'h05);
        chk("single_mulb",  mul_b,  32'h3D);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("single_early_rspv", rsp_valid, 32'h0);
            chk("single_idle",       idle,      32'h0);
        end
        tick();
        chk("single_rspv", rsp_valid, 32'h1);
        chk("single_rspp", rsp_p,     pv(-15));
        tick();
        chk("single_pulse_end", rsp_valid, 32'h0);

        // ---------------- full operand sweep back-to-back from requester 2
        for (int c = 0; c <= 4095 + 9; c++) begin
            if (c >= 9) begin
                j = c - 9;
                p = (j / 64 - 32) * (j % 64 - 32);
                e = {17'b0, 4'b0100, p[PW-1:0]};
                chk("sweep", {17'b0, rsp_valid, rsp_p}, e);
            end
            if (c < 4096) begin
                req_valid = 4'b0100;
                set_ops(2, c / 64 - 32, c % 64 - 32);
            end else begin
                req_valid = '0;
            end
            tick();
        end
        chk("sweep_end", rsp_valid, 32'h0);

        // ---------------- contention from reset, then halt/drain
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) set_ops(i, pa[i], pb[i]);
        req_valid = 4'b1111;
        rst_n     = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            if (c == 20) halt = 1'b1;
            #1;
            chk("cont_ready", req_ready, (c <= 20) ? exp_rr(c) : 32'h0);
            if (c >= 9 && c <= 29) begin
                j = exp_id(c - 9);
                chk("cont_rspv", rsp_valid, 32'h1 << j);
                chk("cont_rspp", rsp_p,     pv(pa[j] * pb[j]));
            end else begin
                chk("cont_rspv_idle", rsp_valid, 32'h0);
            end
            chk("cont_idle", idle, (c >= 30) ? 32'h1 : 32'h0);
            tick();
        end
        halt = 1'b0;
        #1;
        chk("halted_ready", req_ready, 32'h0);
        chk("halted_idle",  idle,      32'h1);
        tick();
        #1;
        chk("resume_idle", idle, 32'h0);
`ifdef MUL_ARB_PRIO_EN
        chk("resume_ready", req_ready, 32'h1);
`else
        chk("resume_ready", req_ready, 32'h2);
`endif

        // ---------------- reset with products in flight
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("no_stale_rspv", rsp_valid, 32'h0);
        end
        req_valid = 4'b0010;
        set_ops(1, -32, -32);
        #1;
        chk("post_rst_ready", req_ready, 32'h2);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 7; k++) tick();
        chk("post_rst_early", rsp_valid, 32'h0);
        tick();
        chk("post_rst_rspv", rsp_valid, 32'h2);
        chk("post_rst_rspp", rsp_p,     pv(-1024));

`ifdef MUL_ARB_PRIO_EN
        // ---------------- fixed priority for requester 0
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("prio_req0", req_ready, 32'h1);
            tick();
        end
        req_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("prio_rr", req_ready, 32'h2 << (k % 3));
            tick();
        end
        req_valid = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
